// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: E-stage bundle between the pipeline and the HI/LO multiply/divide unit.
//   alucontrol  5-bit E-stage control code
//   a, b        rs / rt operands
//   valid_i     E-stage instruction valid
//   flush       E-stage flush (exception / eret)
//   adv_i       E stage advances this cycle
//   busy_o      stall request to the hazard unit
//   hi_o, lo_o  architectural HI / LO
// master: pipeline side (drives controls, reads status); slave: the unit itself.
interface hilo_muldiv_unit_if;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_i;
    logic        flush;
    logic        adv_i;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output alucontrol, a, b, valid_i, flush, adv_i,
        input  busy_o, hi_o, lo_o
    );

    modport slave (
        input  alucontrol, a, b, valid_i, flush, adv_i,
        output busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: owns HI/LO and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// Multiply waits MUL_LAT cycles on a combinational product of latched operands; divide is a
// radix-2 restoring divider (32 iterations + 1 sign fix-up). busy_o stalls the pipeline while
// work is in flight; flush aborts without touching HI/LO.
//   clk     clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     hilo_muldiv_unit_if.slave (controls, operands, busy_o, hi_o, lo_o)
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b11000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b11001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b11011
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b11100
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b11101
`endif

module hilo_muldiv_unit #(
    parameter int unsigned MUL_LAT = 2
) (
    input logic                clk,
    input logic                resetn,
    hilo_muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] x_q, x_d;      // multiplicand, or dividend shifting into quotient
    logic [31:0] y_q, y_d;      // multiplier, or divisor magnitude
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;  // signed multiply
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        bzero_q, bzero_d;

    logic        is_mul, is_div, is_sdiv, go, start;
    logic [31:0] abs_a, abs_b, q_fix, r_fix;
    logic signed [65:0] ext_x, ext_y, prod;
    logic [32:0] shifted, diff;

    always_comb begin
        is_mul  = (bus.alucontrol == `MULT_CONTROL) || (bus.alucontrol == `MULTU_CONTROL);
        is_sdiv = (bus.alucontrol == `DIV_CONTROL);
        is_div  = is_sdiv || (bus.alucontrol == `DIVU_CONTROL);
        go      = bus.valid_i && !bus.flush && (state_q == StIdle);
        start   = go && (is_mul || is_div);
        abs_a   = (is_sdiv && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        abs_b   = (is_sdiv && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

        ext_x   = {{34{sgn_q & x_q[31]}}, x_q};
        ext_y   = {{34{sgn_q & y_q[31]}}, y_q};
        prod    = ext_x * ext_y;

        // Restoring step: trial-subtract the divisor from the shifted partial remainder.
        shifted = {rem_q, x_q[31]};
        diff    = shifted - {1'b0, y_q};

        // Remainder follows the dividend's sign, which also makes the b==0 case yield HI=a.
        q_fix   = bzero_q ? 32'hFFFF_FFFF : (qneg_q ? (~x_q + 32'd1) : x_q);
        r_fix   = rneg_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        x_d     = x_q;
        y_d     = y_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;

        unique case (state_q)
            StIdle: begin
                if (start && is_mul) begin
                    state_d = StMul;
                    count_d = 6'd0;
                    x_d     = bus.a;
                    y_d     = bus.b;
                    sgn_d   = (bus.alucontrol == `MULT_CONTROL);
                end else if (start && is_div) begin
                    state_d = StDiv;
                    count_d = 6'd0;
                    x_d     = abs_a;
                    y_d     = abs_b;
                    rem_d   = 32'd0;
                    qneg_d  = is_sdiv && (bus.a[31] != bus.b[31]);
                    rneg_d  = is_sdiv && bus.a[31];
                    bzero_d = (bus.b == 32'd0);
                end else if (go && (bus.alucontrol == `MTHI_CONTROL)) begin
                    hi_d = bus.a;
                end else if (go && (bus.alucontrol == `MTLO_CONTROL)) begin
                    lo_d = bus.a;
                end
            end
            StMul: begin
                if (bus.flush) begin
                    state_d = StIdle;
                    count_d = 6'd0;
                end else if (count_q == 6'(MUL_LAT - 1)) begin
                    state_d = StDone;
                    count_d = 6'd0;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    count_d = count_q + 6'd1;
                end
            end
            StDiv: begin
                if (bus.flush) begin
                    state_d = StIdle;
                    count_d = 6'd0;
                end else if (count_q == 6'd32) begin
                    state_d = StDone;
                    count_d = 6'd0;
                    lo_d    = q_fix;
                    hi_d    = r_fix;
                end else begin
                    count_d = count_q + 6'd1;
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        x_d   = {x_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        x_d   = {x_q[30:0], 1'b0};
                    end
                end
            end
            StDone: begin
                if (bus.adv_i || bus.flush) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            count_q <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            rem_q   <= 32'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
        end
    end

    // Gated by resetn so a held instruction cannot request a stall during reset.
    assign bus.busy_o = resetn && (start || (state_q == StMul) || (state_q == StDiv));
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
    localparam logic [4:0] OP_MULT  = 5'b11000;
    localparam logic [4:0] OP_MULTU = 5'b11001;
    localparam logic [4:0] OP_DIV   = 5'b11010;
    localparam logic [4:0] OP_DIVU  = 5'b11011;
    localparam logic [4:0] OP_MTHI  = 5'b11100;
    localparam logic [4:0] OP_MTLO  = 5'b11101;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    vec_t sb[$];
    vec_t tbl[13];

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit #(.MUL_LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   cyc;
        int   guard;
        @(posedge clk);
        #1;
        bus.alucontrol = v.op;
        bus.a          = v.a;
        bus.b          = v.b;
        bus.valid_i    = 1'b1;
        bus.flush      = 1'b0;
        bus.adv_i      = 1'b0;
        sb.push_back(v);
        @(negedge clk);
        cyc   = 0;
        guard = 0;
        while (bus.busy_o && guard < 200) begin
            cyc++;
            guard++;
            @(negedge clk);
        end
        if (cyc == 0) @(negedge clk);
        e = sb.pop_front();
        check({tag, " hi"}, bus.hi_o, e.hi);
        check({tag, " lo"}, bus.lo_o, e.lo);
        check({tag, " stall"}, 32'(cyc), 32'(e.cyc));
        // Instruction still present with adv_i low: must hold without relaunching.
        repeat (2) @(negedge clk);
        check({tag, " hold busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, " hold lo"}, bus.lo_o, e.lo);
        @(posedge clk);
        #1;
        bus.adv_i = 1'b1;
        @(posedge clk);
        #1;
        bus.adv_i   = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    initial begin
        vec_t m;
        total          = 0;
        bad            = 0;
        resetn         = 1'b0;
        bus.alucontrol = 5'd0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        bus.valid_i    = 1'b0;
        bus.flush      = 1'b0;
        bus.adv_i      = 1'b0;

        tbl[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 3};
        tbl[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 3};
        tbl[2]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 3};
        tbl[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        tbl[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        tbl[5]  = '{OP_DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003, 34};
        tbl[6]  = '{OP_DIVU,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 34};
        tbl[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        tbl[8]  = '{OP_DIV,   32'hFFFFFF9C, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFF2, 34};
        tbl[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 34};
        tbl[10] = '{OP_DIV,   32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF, 34};
        tbl[11] = '{OP_MTHI,  32'h11111111, 32'h0,        32'h11111111, 32'hFFFFFFFF, 0};
        tbl[12] = '{OP_MTLO,  32'h22222222, 32'h0,        32'h11111111, 32'h22222222, 0};

        repeat (2) @(posedge clk);
        #1;
        check("reset hi", bus.hi_o, 32'd0);
        check("reset lo", bus.lo_o, 32'd0);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Flush mid-divide: HI/LO untouched, busy drops, then MTHI completes without stall.
        @(posedge clk);
        #1;
        bus.alucontrol = OP_DIV;
        bus.a          = 32'd100;
        bus.b          = 32'd3;
        bus.valid_i    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("flush div busy", 32'(bus.busy_o), 32'd0);
        check("flush div hi", bus.hi_o, 32'h11111111);
        check("flush div lo", bus.lo_o, 32'h22222222);
        @(posedge clk);
        #1;
        bus.alucontrol = OP_MTHI;
        bus.a          = 32'hA5A5A5A5;
        bus.valid_i    = 1'b1;
        @(negedge clk);
        check("mthi busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("mthi hi", bus.hi_o, 32'hA5A5A5A5);
        check("mthi lo", bus.lo_o, 32'h22222222);

        // Flush together with start and with MTLO: nothing happens.
        @(posedge clk);
        #1;
        bus.alucontrol = OP_MULT;
        bus.a          = 32'd9;
        bus.b          = 32'd9;
        bus.valid_i    = 1'b1;
        bus.flush      = 1'b1;
        @(negedge clk);
        check("flush+start busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        bus.alucontrol = OP_MTLO;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("flush+mt busy", 32'(bus.busy_o), 32'd0);
        check("flush+mt hi", bus.hi_o, 32'hA5A5A5A5);
        check("flush+mt lo", bus.lo_o, 32'h22222222);

        // Flush on the final multiply edge: no HI/LO write.
        @(posedge clk);
        #1;
        bus.alucontrol = OP_MULTU;
        bus.a          = 32'd7;
        bus.b          = 32'd8;
        bus.valid_i    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("flush last mul busy", 32'(bus.busy_o), 32'd0);
        check("flush last mul hi", bus.hi_o, 32'hA5A5A5A5);
        check("flush last mul lo", bus.lo_o, 32'h22222222);

        // Asynchronous reset mid-divide takes effect immediately.
        @(posedge clk);
        #1;
        bus.alucontrol = OP_DIVU;
        bus.a          = 32'd1000;
        bus.b          = 32'd7;
        bus.valid_i    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resetn      = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        check("async reset hi", bus.hi_o, 32'd0);
        check("async reset lo", bus.lo_o, 32'd0);
        check("async reset busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        m = '{OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 3};
        run_vec(m, "post reset multu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage consumer of the 5-bit ALU control code produced by the ALU decoder.
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiply and divide run multi-cycle and stall the pipeline through busy_o.
- Flush from exception handling aborts in-flight work with no HI/LO side effect.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state before HI/LO write; legal 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- alucontrol  in  5  E-stage control code; the shared defines header macros are used: MULT/MULTU/DIV/DIVU/MTHI/MTLO_CONTROL.
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  32  rt operand (divisor / multiplier).
- valid_i  in  1  E-stage instruction is valid.
- flush  in  1  E-stage flush (exception / eret).
- adv_i  in  1  E stage advances this cycle.
- busy_o  out  1  stall request to hazard unit.
- hi_o  out  32  current HI.
- lo_o  out  32  current LO.

Behaviour:
- Reset (async, resetn=0): HI=LO=0, state=IDLE, iteration counter=0, busy_o=0, all datapath regs cleared. Takes effect immediately, including mid-operation.
- States:
  - IDLE: waiting for work.
  - MUL: multiply in progress.
  - DIV: divide in progress.
  - DONE: result written; holds until the instruction leaves E.
- start = valid_i & !flush & state==IDLE & alucontrol in {MULT, MULTU, DIV, DIVU}.
- IDLE transitions:
  - start with MULT*: latch operands, go to MUL, count=0.
  - start with DIV*: latch operands, go to DIV, count=0.
  - valid_i & !flush & MTHI: HI<=a at edge, stay IDLE, no stall.
  - valid_i & !flush & MTLO: LO<=a at edge, stay IDLE, no stall.
- MUL:
  - Compute the 64-bit product: signed for MULT, unsigned for MULTU.
  - After MUL_LAT cycles: {HI,LO}<=product, go to DONE.
- DIV: radix-2 restoring divider on operand magnitudes.
  - Unsigned magnitudes for DIVU; absolute values for DIV.
  - 32 iteration cycles, then 1 fix-up cycle: 33 cycles in DIV.
  - Fix-up for DIV: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Fix-up edge: LO<=quotient, HI<=remainder, go to DONE.
- Divide boundary cases:
  - b==0: LO=32'hFFFFFFFF, HI=a. Same 33-cycle latency.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- busy_o: combinational; 1 when start is true, and every cycle in MUL or DIV; 0 in IDLE without start and in DONE.
- Stall lengths: MULT* = MUL_LAT+1 cycles; DIV* = 34 cycles.
- DONE: busy_o=0, start suppressed, so the still-present instruction does not re-launch. DONE→IDLE on adv_i or flush; otherwise hold.
- flush in MUL/DIV/DONE: next edge to IDLE; HI/LO unchanged; partial results discarded; busy_o=0 the cycle after the flush.
- Simultaneous events:
  - flush with start, or flush with MTHI/MTLO: flush wins, nothing changes.
  - flush on the final MUL/DIV edge: flush wins, no HI/LO write.
- hi_o/lo_o are register outputs; a new value is visible the cycle after the writing edge.
- MFHI/MFLO forwarding is outside this block.
- alucontrol codes other than the six handled are ignored.

Test Plan:
- MULT a=0xFFFFFFFE, b=3, MUL_LAT=2, adv_i=0:
  - busy_o high exactly 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Stays in DONE with busy_o=0 until adv_i pulses; no relaunch.
- MULTU a=0xFFFFFFFE, b=3 -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2:
  - busy_o high 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU a=7, b=2 -> LO=3, HI=1.
- Divide corner cases:
  - DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678.
  - DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush, then move-to:
  - Start DIV with HI=0x11111111, LO=0x22222222; assert flush on iteration 10.
  - busy_o=0 next cycle; HI/LO unchanged; state IDLE.
  - Then MTHI a=0xA5A5A5A5 -> hi_o=0xA5A5A5A5 next cycle; no stall.
- Reset mid-operation: resetn low mid-DIV -> immediately HI=LO=0, busy_o=0; after release, a MULTU 5×6 yields LO=30, HI=0.
